// File: rtl/bp_pkg.sv
// Shared types and constants for the dynamic branch predictor.
package bp_pkg;

  // Fetch fall-through increment (one RV32I instruction).
  localparam int unsigned BP_PC_INC    = 4;

  // Entry fields are sized for the widest supported PC (64 bits) and the
  // smallest table (4 entries). The predictor zero-extends narrower values
  // into these fields. Synthesis removes the flops that stay constant.
  localparam int unsigned BP_PC_W_MAX  = 64;
  localparam int unsigned BP_TAG_W_MAX = BP_PC_W_MAX - 2 - 2;

  // 2-bit saturating counter states.
  typedef enum logic [1:0] {
    SN = 2'b00,
    WN = 2'b01,
    WT = 2'b10,
    ST = 2'b11
  } cnt_e;

  typedef struct packed {
    logic                    valid;
    logic [BP_TAG_W_MAX-1:0] tag;
    logic [BP_PC_W_MAX-1:0]  target;
    cnt_e                    cnt;
    logic                    jmp;
  } bp_entry_t;

endpackage

// File: rtl/bp_sat_cnt.sv
// 2-bit saturating counter next-state function (combinational).
module bp_sat_cnt
  import bp_pkg::*;
(
  input  cnt_e cnt_i,
  input  logic taken_i,
  output cnt_e cnt_next_o
);

  // Step toward taken/not-taken and hold at the SN and ST ends.
  always_comb begin
    cnt_next_o = cnt_i;
    case (cnt_i)
      SN:      cnt_next_o = taken_i ? WN : SN;
      WN:      cnt_next_o = taken_i ? WT : SN;
      WT:      cnt_next_o = taken_i ? ST : WN;
      ST:      cnt_next_o = taken_i ? ST : WT;
      default: cnt_next_o = cnt_i;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters. Fetch lookup is combinational.
// Execute update is registered. The block also raises the mispredict flag,
// gives the redirect PC, and keeps the performance counters.
// Optional build macro BP_GSHARE_EN XORs a global history register into the index.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES  = 64,
  parameter int unsigned PC_W     = 32,
  parameter logic [1:0]  CNT_INIT = 2'b01
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [PC_W-1:0] if_pc_i,
  output logic            pred_taken_o,
  output logic [PC_W-1:0] pred_target_o,
  input  logic            ex_update_i,
  input  logic            ex_is_jump_i,
  input  logic [PC_W-1:0] ex_pc_i,
  input  logic            ex_taken_i,
  input  logic [PC_W-1:0] ex_target_i,
  input  logic            ex_pred_taken_i,
  input  logic [PC_W-1:0] ex_pred_target_i,
  output logic            mispredict_o,
  output logic [PC_W-1:0] redirect_pc_o,
  output logic [31:0]     br_cnt_o,
  output logic [31:0]     mispred_cnt_o
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = PC_W - IDX_W - 2;

  bp_entry_t tbl [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] if_tag;
  logic [TAG_W-1:0] ex_tag;

  assign if_tag = if_pc_i[PC_W-1:IDX_W+2];
  assign ex_tag = ex_pc_i[PC_W-1:IDX_W+2];

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr;

  assign if_idx = if_pc_i[IDX_W+1:2] ^ ghr;
  assign ex_idx = ex_pc_i[IDX_W+1:2] ^ ghr;

  // Shift in the outcomes of conditional branches. Jumps leave the history unchanged.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ghr <= '0;
    end else if (ex_update_i && !ex_is_jump_i) begin
      ghr <= {ghr[IDX_W-2:0], ex_taken_i};
    end
  end
`else
  assign if_idx = if_pc_i[IDX_W+1:2];
  assign ex_idx = ex_pc_i[IDX_W+1:2];
`endif

  bp_entry_t if_ent;
  logic      if_hit;
  logic      if_dir;

  // Fetch lookup. It sees the table as it was before this cycle's update.
  always_comb begin
    if_ent        = tbl[if_idx];
    if_hit        = if_ent.valid && (if_ent.tag == BP_TAG_W_MAX'(if_tag));
    if_dir        = if_ent.jmp || (if_ent.cnt == WT) || (if_ent.cnt == ST);
    pred_taken_o  = if_hit && if_dir;
    pred_target_o = pred_taken_o ? PC_W'(if_ent.target)
                                 : if_pc_i + PC_W'(BP_PC_INC);
  end

  logic ex_hit;
  cnt_e ex_cnt;
  cnt_e ex_cnt_next;

  assign ex_hit = tbl[ex_idx].valid && (tbl[ex_idx].tag == BP_TAG_W_MAX'(ex_tag));
  assign ex_cnt = tbl[ex_idx].cnt;

  bp_sat_cnt u_sat_cnt (
    .cnt_i      (ex_cnt),
    .taken_i    (ex_taken_i),
    .cnt_next_o (ex_cnt_next)
  );

  // Resolve the branch. A taken branch with a wrong target also counts as a mispredict.
  always_comb begin
    mispredict_o  = ex_update_i &&
                    ((ex_taken_i != ex_pred_taken_i) ||
                     (ex_taken_i && (ex_target_i != ex_pred_target_i)));
    redirect_pc_o = ex_taken_i ? ex_target_i : ex_pc_i + PC_W'(BP_PC_INC);
  end

  // Table update. On a hit, train the entry. On a taken miss, allocate or replace the entry.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tbl[i].valid <= 1'b0;
        tbl[i].cnt   <= cnt_e'(CNT_INIT);
        tbl[i].jmp   <= 1'b0;
      end
    end else if (ex_update_i) begin
      if (ex_hit) begin
        tbl[ex_idx].cnt <= ex_cnt_next;
        tbl[ex_idx].jmp <= ex_is_jump_i;
        if (ex_taken_i) begin
          tbl[ex_idx].target <= BP_PC_W_MAX'(ex_target_i);
        end
      end else if (ex_taken_i) begin
        tbl[ex_idx].valid  <= 1'b1;
        tbl[ex_idx].tag    <= BP_TAG_W_MAX'(ex_tag);
        tbl[ex_idx].target <= BP_PC_W_MAX'(ex_target_i);
        tbl[ex_idx].jmp    <= ex_is_jump_i;
        tbl[ex_idx].cnt    <= ex_is_jump_i ? ST : WT;
      end
    end
  end

  // Performance counters. They wrap at 2^32.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      br_cnt_o      <= '0;
      mispred_cnt_o <= '0;
    end else begin
      if (ex_update_i) begin
        br_cnt_o <= br_cnt_o + 32'd1;
      end
      if (mispredict_o) begin
        mispred_cnt_o <= mispred_cnt_o + 32'd1;
      end
    end
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage RV32I pipeline.
- Replaces static predict-not-taken behaviour.
- Fetch side: 0-cycle combinational lookup of a direct-mapped table (BTB + 2-bit saturating counters).
- Execute side: sequential update with resolved outcomes, mispredict flag and redirect PC, plus performance counters.

Parameters:
- ENTRIES, 64, table depth; power of two, ≥4; IDX_W = $clog2(ENTRIES).
- PC_W, 32, PC/target width; TAG_W = PC_W-IDX_W-2.
- CNT_INIT, 2'b01, counter value on reset/invalid (weakly not-taken).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- if_pc_i  in  PC_W  fetch PC
- pred_taken_o  out  1  predict taken
- pred_target_o  out  PC_W  predicted next PC
- ex_update_i  in  1  resolved branch/jump in EX this cycle
- ex_is_jump_i  in  1  1 = JAL/JALR, 0 = conditional branch
- ex_pc_i  in  PC_W  PC of resolved instruction
- ex_taken_i  in  1  actual outcome
- ex_target_i  in  PC_W  actual target
- ex_pred_taken_i  in  1  prediction carried down the pipe
- ex_pred_target_i  in  PC_W  predicted target carried down the pipe
- mispredict_o  out  1  flush request
- redirect_pc_o  out  PC_W  correct next PC
- br_cnt_o  out  32  resolved updates count
- mispred_cnt_o  out  32  mispredict count

Behaviour:
- Clock and reset: one clock (clk_i). Reset is synchronous and active-low (rst_ni); all state changes occur on posedge clk_i only.
- Indexing: idx = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2].
- Entry fields: valid, tag, target, cnt[1:0], jmp.
- Lookup (combinational, 0 latency):
  - hit = valid[idx] && tag match.
  - pred_taken_o = hit && (jmp || cnt[1]).
  - pred_target_o = pred_taken_o ? target : if_pc_i+4 (mod 2^PC_W).
- Counter states: 00 SN, 01 WN, 10 WT, 11 ST. Saturating: 11 +taken stays 11; 00 +not-taken stays 00.
- Update, at posedge when ex_update_i=1:
  - Hit: cnt saturating inc/dec per ex_taken_i. If taken, target ← ex_target_i. jmp ← ex_is_jump_i.
  - Miss and taken: allocate or replace the entry. valid=1, tag, target, jmp; cnt = 10 if conditional, 11 if jump.
  - Miss and not-taken: no table write.
- Read/write same index in the same cycle: lookup returns pre-update contents (no bypass).
- Mispredict (combinational on EX inputs, gated by ex_update_i): ex_taken_i≠ex_pred_taken_i, or (ex_taken_i && ex_target_i≠ex_pred_target_i).
- redirect_pc_o = ex_taken_i ? ex_target_i : ex_pc_i+4.
- Performance counters: br_cnt_o +1 per ex_update_i; mispred_cnt_o +1 per mispredict_o. Both wrap at 2^32.
- Reset (rst_ni=0 at posedge):
  - All valid cleared; all cnt=CNT_INIT; jmp=0; counters=0. Tags and targets are don't-care.
  - Reset beats any simultaneous update.
  - Outputs during/after reset: pred_taken_o=0, pred_target_o=if_pc_i+4, mispredict_o follows inputs gated by ex_update_i.
- Reset mid-operation: takes effect in one cycle; no partial update.
- Unaligned PCs: bits [1:0] are ignored.

Optional Feature:
- Macro: BP_GSHARE_EN.
- Defined:
  - IDX_W-bit global history register ghr, reset 0.
  - idx = pc[IDX_W+1:2] ^ ghr for both lookup and update.
  - Update uses ghr before its own shift.
  - On each conditional update: ghr ← {ghr[IDX_W-2:0], ex_taken_i}. Jumps do not shift.
  - Tag is still taken from the PC.
- Undefined: pure PC indexing; no ghr flops.

Decomposition:
- Package bp_pkg:
  - cnt_e enum (SN, WN, WT, ST).
  - bp_entry_t struct (valid, tag, target, cnt, jmp), parametrised via localparam widths.
  - BP_PC_INC = 4.
- Sub-module bp_sat_cnt: 2-bit saturating next-state function, combinational; instantiated in the update path.

Test Plan:
- Reset, then if_pc_i=0x100 → pred_taken_o=0, pred_target_o=0x104; br_cnt_o=0, mispred_cnt_o=0.
- Update pc=0x100, taken, target=0x80, conditional, pred_taken=0 → mispredict_o=1, redirect_pc_o=0x80. Next cycle lookup 0x100 → pred_taken_o=1, target 0x80, cnt=WT.
- Same branch not-taken twice → cnt 10→01→00; lookup predicts not-taken, target 0x104. Third not-taken keeps 00.
- Aliasing, ENTRIES=64: allocate 0x100 taken, then 0x200 taken (same idx, different tag) → lookup 0x100 misses, lookup 0x200 hits.
- Update and lookup of 0x300 in the same cycle → old miss is returned; the hit is visible the next cycle. Update with rst_ni=0 → table stays empty, counters stay 0.
- JAL at 0x40 to 0x400 → jmp=1, cnt=ST, predicted taken. With BP_GSHARE_EN: T,N,T conditional updates → ghr=3'b101 in the low bits, and the index is XORed accordingly.
